// File: rtl/dm_pkg.sv
// Shared types and constants for the wait-state data-memory responder.
// Consumed by the responder FSM and its word array.
package dm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam int CNT_W  = 4;
    localparam int DATA_W = 32;
    localparam int BYTES  = DATA_W / 8;

    localparam logic [BYTES-1:0] BE_WORD = 4'b1111;
    localparam logic [BYTES-1:0] BE_NONE = 4'b0000;

endpackage

// File: rtl/dm_wait_responder_if.sv
// Request/response bundle between the core's load/store path and the
// data-memory responder.
interface dm_wait_responder_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;
    logic              busy;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata, busy
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata, busy
    );
endinterface

// File: rtl/dm_word_array.sv
// Word-wide synchronous RAM with per-byte write enables and a registered
// read port that holds its value between reads.
module dm_word_array
    import dm_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BYTES-1:0]  be,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    // Array contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be[i]) begin
                    mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (rd_en) begin
            rdata_d = mem_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dm_wait_responder.sv
// Data-memory responder: latches a request, waits LATENCY cycles, commits
// the access to the word array, then pulses ack for one cycle.
module dm_wait_responder
    import dm_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                rst,
    dm_wait_responder_if.slave  bus
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("dm_wait_responder: LATENCY must be within 1..15");
    end

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BYTES-1:0]  be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              commit;
    logic              accept;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        commit  = 1'b0;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                accept = bus.req;
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    commit  = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                // A request on the ack cycle is taken straight into WAIT.
                accept  = bus.req;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
            we_d    = bus.we;
            addr_d  = bus.addr;
            be_d    = bus.be;
            wdata_d = bus.wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        be_q    <= be_d;
        wdata_q <= wdata_d;
    end

    // Reset at the commit edge aborts the access entirely.
    dm_word_array #(
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .wr_en (commit &  we_q & ~rst),
        .rd_en (commit & ~we_q & ~rst),
        .addr  (addr_q),
        .be    (be_q),
        .wdata (wdata_q),
        .rdata (bus.rdata)
    );

    assign bus.ack  = (state_q == RESP);
    assign bus.busy = (state_q != IDLE);

endmodule

// File: tb/tb_dm_wait_responder.sv
// Self-checking bench for dm_wait_responder: three instances with
// LATENCY 1, 2 and 4, vector table, corner sequences and random traffic.
module tb_dm_wait_responder;

    localparam int AW = 10;
    localparam int LAT [3] = '{1, 2, 4};

    typedef struct {
        bit          we;
        logic [9:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    logic [2:0]  req_v, we_v;
    logic [9:0]  addr_v  [3];
    logic [3:0]  be_v    [3];
    logic [31:0] wdata_v [3];
    logic [2:0]  ack_v, busy_v;
    logic [31:0] rdata_v [3];

    int n_chk  = 0;
    int n_fail = 0;
    logic [31:0] mdl [int];

    always #5 clk = ~clk;

    dm_wait_responder_if #(.ADDR_W(AW)) if0 ();
    dm_wait_responder_if #(.ADDR_W(AW)) if1 ();
    dm_wait_responder_if #(.ADDR_W(AW)) if2 ();

    assign if0.req = req_v[0]; assign if0.we = we_v[0]; assign if0.addr = addr_v[0];
    assign if0.be = be_v[0]; assign if0.wdata = wdata_v[0];
    assign if1.req = req_v[1]; assign if1.we = we_v[1]; assign if1.addr = addr_v[1];
    assign if1.be = be_v[1]; assign if1.wdata = wdata_v[1];
    assign if2.req = req_v[2]; assign if2.we = we_v[2]; assign if2.addr = addr_v[2];
    assign if2.be = be_v[2]; assign if2.wdata = wdata_v[2];
    assign ack_v  = {if2.ack, if1.ack, if0.ack};
    assign busy_v = {if2.busy, if1.busy, if0.busy};
    assign rdata_v[0] = if0.rdata;
    assign rdata_v[1] = if1.rdata;
    assign rdata_v[2] = if2.rdata;

    dm_wait_responder #(.ADDR_W(AW), .LATENCY(1)) u_l1 (.clk(clk), .rst(rst_v[0]), .bus(if0));
    dm_wait_responder #(.ADDR_W(AW), .LATENCY(2)) u_l2 (.clk(clk), .rst(rst_v[1]), .bus(if1));
    dm_wait_responder #(.ADDR_W(AW), .LATENCY(4)) u_l4 (.clk(clk), .rst(rst_v[2]), .bus(if2));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mdl_rd(input int k, input logic [9:0] a);
        int key = k * 1024 + int'(a);
        return mdl.exists(key) ? mdl[key] : 32'h0;
    endfunction

    task automatic mdl_wr(input int k, input logic [9:0] a, input logic [3:0] be,
                          input logic [31:0] d);
        mdl[k * 1024 + int'(a)] = merge(mdl_rd(k, a), d, be);
    endtask

    // One complete transaction; request inputs are scrambled after accept.
    task automatic xact(input int k, input bit w, input logic [9:0] a, input logic [3:0] b,
                        input logic [31:0] d, input logic [31:0] exp, input string nm);
        int  c;
        bit  busy_ok = 1'b1;
        @(negedge clk);
        req_v[k] = 1'b1; we_v[k] = w; addr_v[k] = a; be_v[k] = b; wdata_v[k] = d;
        @(negedge clk);
        req_v[k] = 1'b0; we_v[k] = ~w; addr_v[k] = ~a; be_v[k] = ~b; wdata_v[k] = ~d;
        c = 1;
        while (!ack_v[k] && c < 40) begin
            if (!busy_v[k]) busy_ok = 1'b0;
            @(negedge clk);
            c++;
        end
        chk({nm, "_latency"}, 32'(c), 32'(LAT[k] + 1));
        chk({nm, "_busy_wait"}, {31'b0, busy_ok & busy_v[k]}, 32'h1);
        if (w) mdl_wr(k, a, b, d);
        else   chk({nm, "_rdata"}, rdata_v[k], exp);
        @(negedge clk);
        chk({nm, "_ack_drop"}, {30'b0, ack_v[k], busy_v[k]}, 32'h0);
        if (!w) chk({nm, "_rdata_hold"}, rdata_v[k], exp);
    endtask

    vec_t tbl [10];

    initial begin
        int        acks, ack_pos, c;
        logic [9:0] pool [6];

        rst_v = 3'b111; req_v = '0; we_v = '0;
        for (int k = 0; k < 3; k++) begin
            addr_v[k] = '0; be_v[k] = '0; wdata_v[k] = '0;
        end

        tbl[0] = '{1'b1, 10'h004, 4'b1111, 32'hDEADBEEF, 32'h0};
        tbl[1] = '{1'b0, 10'h004, 4'b0000, 32'h0,        32'hDEADBEEF};
        tbl[2] = '{1'b1, 10'h010, 4'b1111, 32'h11223344, 32'h0};
        tbl[3] = '{1'b1, 10'h010, 4'b0101, 32'hAABBCCDD, 32'h0};
        tbl[4] = '{1'b0, 10'h010, 4'b1111, 32'h0,        32'h11BB33DD};
        tbl[5] = '{1'b1, 10'h010, 4'b0000, 32'hFFFFFFFF, 32'h0};
        tbl[6] = '{1'b0, 10'h010, 4'b0011, 32'h0,        32'h11BB33DD};
        tbl[7] = '{1'b1, 10'h000, 4'b1111, 32'h12345678, 32'h0};
        tbl[8] = '{1'b1, 10'h3FF, 4'b1111, 32'hCAFEF00D, 32'h0};
        tbl[9] = '{1'b0, 10'h3FF, 4'b1111, 32'h0,        32'hCAFEF00D};

        // Reset held two cycles, then idle
        repeat (2) @(negedge clk);
        rst_v = 3'b000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("reset_idle_k%0d", k),
                    {30'b0, ack_v[k], busy_v[k]} | rdata_v[k], 32'h0);
            end
        end

        // Vector table, LATENCY=2
        for (int i = 0; i < 10; i++) begin
            xact(1, tbl[i].we, tbl[i].addr, tbl[i].be, tbl[i].wdata, tbl[i].exp_rdata,
                 $sformatf("tbl%0d", i));
        end
        xact(1, 1'b0, 10'h000, 4'b1111, 32'h0, 32'h12345678, "wrap_no_alias");

        // Back-to-back, LATENCY=1: write then read of addr 3 with req held high
        @(negedge clk);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 10'd3; be_v[0] = 4'hF; wdata_v[0] = 32'h5;
        @(negedge clk);
        chk("b2b_wait1", {30'b0, ack_v[0], busy_v[0]}, 32'h1);
        @(negedge clk);
        chk("b2b_ack1", {30'b0, ack_v[0], busy_v[0]}, 32'h3);
        we_v[0] = 1'b0; wdata_v[0] = 32'h0;
        @(negedge clk);
        req_v[0] = 1'b0;
        chk("b2b_wait2", {30'b0, ack_v[0], busy_v[0]}, 32'h1);
        @(negedge clk);
        chk("b2b_ack2", {30'b0, ack_v[0], busy_v[0]}, 32'h3);
        chk("b2b_rdata", rdata_v[0], 32'h5);
        mdl_wr(0, 10'd3, 4'hF, 32'h5);
        @(negedge clk);
        chk("b2b_idle", {30'b0, ack_v[0], busy_v[0]}, 32'h0);

        // Reset mid-WAIT, LATENCY=4: write to addr 7 must not land
        xact(2, 1'b1, 10'd7, 4'hF, 32'h0, 32'h0, "pre7");
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 10'd7; be_v[2] = 4'hF; wdata_v[2] = 32'hFFFFFFFF;
        @(negedge clk);
        req_v[2] = 1'b0;
        @(negedge clk);
        rst_v[2] = 1'b1;
        @(negedge clk);
        rst_v[2] = 1'b0;
        chk("rst_wait_idle", {30'b0, ack_v[2], busy_v[2]}, 32'h0);
        acks = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            acks += int'(ack_v[2]);
        end
        chk("rst_wait_no_ack", 32'(acks), 32'h0);
        xact(2, 1'b0, 10'd7, 4'hF, 32'h0, 32'h0, "rst_wait_read7");

        // Reset during RESP: the write has already committed
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 10'd8; be_v[2] = 4'hF; wdata_v[2] = 32'hAAAA5555;
        @(negedge clk);
        req_v[2] = 1'b0;
        c = 1;
        while (!ack_v[2] && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("rst_resp_latency", 32'(c), 32'd5);
        rst_v[2] = 1'b1;
        @(negedge clk);
        rst_v[2] = 1'b0;
        chk("rst_resp_drop", {30'b0, ack_v[2], busy_v[2]}, 32'h0);
        mdl_wr(2, 10'd8, 4'hF, 32'hAAAA5555);
        xact(2, 1'b0, 10'd8, 4'h0, 32'h0, 32'hAAAA5555, "rst_resp_read8");

        // Requests toggled during WAIT are ignored
        xact(2, 1'b1, 10'd21, 4'hF, 32'h21212121, 32'h0, "pre21");
        @(negedge clk);
        req_v[2] = 1'b1; we_v[2] = 1'b1; addr_v[2] = 10'd20; be_v[2] = 4'hF; wdata_v[2] = 32'h20202020;
        acks = 0; ack_pos = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            req_v[2] = (i < 4) && (i % 2 == 1);
            addr_v[2] = 10'd21; wdata_v[2] = 32'hBADBAD00;
            if (ack_v[2]) begin
                acks++;
                ack_pos = i;
            end
        end
        chk("ignore_one_ack", 32'(acks), 32'h1);
        chk("ignore_ack_pos", 32'(ack_pos), 32'd5);
        mdl_wr(2, 10'd20, 4'hF, 32'h20202020);
        xact(2, 1'b0, 10'd20, 4'hF, 32'h0, 32'h20202020, "ignore_read20");
        xact(2, 1'b0, 10'd21, 4'hF, 32'h0, 32'h21212121, "ignore_read21");

        // Random traffic against the byte-merge memory model
        pool = '{10'h000, 10'h001, 10'h002, 10'h155, 10'h3FE, 10'h3FF};
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 30; n++) begin
                logic [9:0]  a = pool[$urandom_range(0, 5)];
                bit          w = $urandom_range(0, 1) == 1;
                logic [3:0]  b = 4'($urandom);
                logic [31:0] d = $urandom;
                if (!mdl.exists(k * 1024 + int'(a))) begin
                    w = 1'b1;
                    b = 4'hF;
                end
                xact(k, w, a, b, d, mdl_rd(k, a), $sformatf("rnd_k%0d_%0d", k, n));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
